if_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the IF/ID pipeline register. It holds the program counter and runs a req/ready handshake to instruction memory. It then presents the fetched instruction and its PC+4 to IF/ID. It honours the hazard unit's stall (`pc_write` low) and redirects on a taken branch or jump, delivering a zero bubble, which decodes as a NOP, whenever no valid instruction is available.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_pc_reg.sv | 44 ++++
 rtl/if_fetch_unit.sv | 110 +++++++++++
 tb/tb_if_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HAVE = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'd0;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter with increment/redirect muxing, plus the address of a
// request abandoned by a redirect while still outstanding.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_advance,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  input  logic            i_capture_drop,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_drop_addr
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_drop_addr;
  logic            w_unused_target_lsbs;

  // Targets are forced word-aligned; the low bits carry no information.
  assign w_unused_target_lsbs = ^i_target[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc        <= RESET_PC;
      r_drop_addr <= 32'd0;
    end else begin
      if (i_redirect) begin
        r_pc <= {i_target[XLEN-1:2], 2'b00};
      end else if (i_advance) begin
        r_pc <= r_pc + PC_INC;
      end
      if (i_capture_drop) begin
        r_drop_addr <= r_pc;
      end
    end
  end

  assign o_pc        = r_pc;
  assign o_drop_addr = r_drop_addr;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding IF/ID: req/ready fetch, stall and redirect.
// Optional FETCH_BYPASS_EN forwards zero-wait read data straight to IF/ID.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_write,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PC_4_out,
  output logic [XLEN-1:0] Instruction_out,
  output logic            fetch_valid
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_instr_buf;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_drop_addr;
  logic            w_advance;
  logic            w_capture_drop;
  logic            w_bypass;

`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_state == S_REQ) && imem_ready && pc_write && !branch_taken;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_advance      = ((r_state == S_HAVE) && pc_write && !branch_taken) || w_bypass;
  // Redirect while a request is still outstanding: remember its address.
  assign w_capture_drop = (r_state == S_REQ) && branch_taken && !imem_ready;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk            (clk),
    .rst            (rst),
    .i_advance      (w_advance),
    .i_redirect     (branch_taken),
    .i_target       (branch_target),
    .i_capture_drop (w_capture_drop),
    .o_pc           (w_pc),
    .o_drop_addr    (w_drop_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_REQ;
      r_instr_buf <= NOP_INSTR;
    end else begin
      case (r_state)
        S_REQ: begin
          if (branch_taken) begin
            r_state <= imem_ready ? S_REQ : S_DROP;
          end else if (imem_ready && !w_bypass) begin
            r_instr_buf <= imem_rdata;
            r_state     <= S_HAVE;
          end
        end
        S_HAVE: begin
          if (branch_taken || pc_write) begin
            r_state <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_ready) begin
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Outputs decode from state; only the bypass path looks at memory data.
  always_comb begin
    imem_req        = 1'b0;
    imem_addr       = w_pc;
    fetch_valid     = 1'b0;
    Instruction_out = NOP_INSTR;
    case (r_state)
      S_REQ: begin
        imem_req = 1'b1;
        if (w_bypass) begin
          fetch_valid     = 1'b1;
          Instruction_out = imem_rdata;
        end
      end
      S_HAVE: begin
        fetch_valid     = 1'b1;
        Instruction_out = r_instr_buf;
      end
      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = w_drop_addr;
      end
      default: ;
    endcase
  end

  assign PC_4_out = w_pc + PC_INC;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit (RESET_PC = 0x100).
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        pc_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_4_out;
  logic [31:0] Instruction_out;
  logic        fetch_valid;

  int n_checks;
  int n_fail;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0100)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_4_out        (PC_4_out),
    .Instruction_out (Instruction_out),
    .fetch_valid     (fetch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Apply this cycle's inputs, then let combinational outputs settle.
  task automatic drive(input logic pw, input logic br, input logic [31:0] tgt,
                       input logic rdy, input logic [31:0] rd);
    pc_write      = pw;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_rdata    = rd;
    #1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

    // Reset values
    chk("rst_req",   32'(imem_req), 32'd1);
    chk("rst_addr",  imem_addr, 32'h100);
    chk("rst_fv",    32'(fetch_valid), 32'd0);
    chk("rst_instr", Instruction_out, 32'h0);
    chk("rst_pc4",   PC_4_out, 32'h104);

    next_cycle();
    rst = 1'b0;

    // Sequential fetch, zero-wait memory
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    chk("seq0_req",  32'(imem_req), 32'd1);
    chk("seq0_addr", imem_addr, 32'h100);
    chk("seq0_pc4",  PC_4_out, 32'h104);
`ifndef FETCH_BYPASS_EN
    chk("seq0_fv",   32'(fetch_valid), 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("seq1_fv",    32'(fetch_valid), 32'd1);
    chk("seq1_instr", Instruction_out, 32'h1111_1111);
    chk("seq1_req",   32'(imem_req), 32'd0);
    chk("seq1_pc4",   PC_4_out, 32'h104);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk("seq2_addr", imem_addr, 32'h104);
    chk("seq2_fv",   32'(fetch_valid), 32'd0);
    chk("seq2_pc4",  PC_4_out, 32'h108);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("seq3_instr", Instruction_out, 32'h2222_2222);
    next_cycle();
`else
    chk("seq0_fv",   32'(fetch_valid), 32'd1);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h2222_2222);
    chk("seq2_addr", imem_addr, 32'h104);
    chk("seq2_instr", Instruction_out, 32'h2222_2222);
    next_cycle();
`endif

    // Stall in S_HAVE holding 0xDEADBEEF (pc_write low during capture)
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
    chk("stall_addr", imem_addr, 32'h108);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk($sformatf("stall%0d_fv", i),    32'(fetch_valid), 32'd1);
      chk($sformatf("stall%0d_instr", i), Instruction_out, 32'hDEAD_BEEF);
      chk($sformatf("stall%0d_pc4", i),   PC_4_out, 32'h10C);
      chk($sformatf("stall%0d_req", i),   32'(imem_req), 32'd0);
      next_cycle();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle();
    chk("release_req",  32'(imem_req), 32'd1);
    chk("release_addr", imem_addr, 32'h10C);

    // Redirect to 0x40 with ready high: the 0x10C data is discarded
    drive(1'b1, 1'b1, 32'h40, 1'b1, 32'hAAAA_AAAA);
    next_cycle();
    // Redirect to 0x203 while the 0x40 request waits 2 cycles
    drive(1'b1, 1'b1, 32'h203, 1'b0, 32'h0);
    chk("br_a_addr", imem_addr, 32'h40);
    chk("br_a_fv",   32'(fetch_valid), 32'd0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("drop_w_req",  32'(imem_req), 32'd1);
    chk("drop_w_addr", imem_addr, 32'h40);
    chk("drop_w_fv",   32'(fetch_valid), 32'd0);
    chk("drop_w_pc4",  PC_4_out, 32'h204);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'hBADB_AD00);
    chk("drop_r_addr",  imem_addr, 32'h40);
    chk("drop_r_fv",    32'(fetch_valid), 32'd0);
    chk("drop_r_instr", Instruction_out, 32'h0);
    next_cycle();
    // New target fetched; stall so it parks in S_HAVE in either build
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h3333_3333);
    chk("tgt_addr", imem_addr, 32'h200);
    chk("tgt_req",  32'(imem_req), 32'd1);
    chk("tgt_fv",   32'(fetch_valid), 32'd0);
    next_cycle();

    // Redirect coincident with stall in S_HAVE: redirect wins
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    chk("have_instr", Instruction_out, 32'h3333_3333);
    chk("have_pc4",   PC_4_out, 32'h204);
    next_cycle();
    drive(1'b0, 1'b0, 32'h0, 1'b1, 32'h4444_4444);
    chk("brst_fv",    32'(fetch_valid), 32'd0);
    chk("brst_instr", Instruction_out, 32'h0);
    chk("brst_addr",  imem_addr, 32'hFFFF_FFFC);
    chk("wrap_pc4",   PC_4_out, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_instr", Instruction_out, 32'h4444_4444);
    next_cycle();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4b", PC_4_out, 32'h4);

    // Zero-wait stream of 8 instructions
`ifdef FETCH_BYPASS_EN
    for (int j = 0; j < 8; j++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h5000_0000 + 32'(j));
      chk($sformatf("str%0d_addr", j),  imem_addr, 32'(j * 4));
      chk($sformatf("str%0d_fv", j),    32'(fetch_valid), 32'd1);
      chk($sformatf("str%0d_instr", j), Instruction_out, 32'h5000_0000 + 32'(j));
      next_cycle();
    end
`else
    for (int j = 0; j < 16; j++) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h5000_0000 + 32'(j / 2));
      if (j % 2 == 0) begin
        chk($sformatf("str%0d_addr", j), imem_addr, 32'((j / 2) * 4));
        chk($sformatf("str%0d_fv", j),   32'(fetch_valid), 32'd0);
      end else begin
        chk($sformatf("str%0d_fv", j),    32'(fetch_valid), 32'd1);
        chk($sformatf("str%0d_instr", j), Instruction_out, 32'h5000_0000 + 32'(j / 2));
      end
      next_cycle();
    end
`endif

    // Asynchronous reset in the middle of the stream
    drive(1'b1, 1'b0, 32'h0, 1'b1, 32'h6666_6666);
    @(posedge clk);
    #2;
    rst        = 1'b1;
    imem_ready = 1'b0;
    #1;
    chk("arst_req",   32'(imem_req), 32'd1);
    chk("arst_addr",  imem_addr, 32'h100);
    chk("arst_fv",    32'(fetch_valid), 32'd0);
    chk("arst_instr", Instruction_out, 32'h0);
    chk("arst_pc4",   PC_4_out, 32'h104);
    next_cycle();
    rst = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
